// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies, helpers.
package mdu_pkg;

    localparam int unsigned MDU_XLEN        = 32;
    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // True for the ops that occupy the unit for multiple cycles.
    function automatic logic is_mul_div(input md_op_e op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// E-stage request/response bundle between the pipeline and the mul/div unit.
interface mul_div_unit_if;
    import mdu_pkg::*;

    logic                start;
    md_op_e              md_op;
    logic [MDU_XLEN-1:0] a;
    logic [MDU_XLEN-1:0] b;
    logic                d_is_md;
    logic                busy;
    logic                md_stall;
    logic [MDU_XLEN-1:0] rd_data;

    modport master (
        output start, md_op, a, b, d_is_md,
        input  busy, md_stall, rd_data
    );

    modport slave (
        input  start, md_op, a, b, d_is_md,
        output busy, md_stall, rd_data
    );

endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MT/MF access.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);

    localparam int unsigned XLEN       = MDU_XLEN;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    md_op_e              op_q;
    logic [XLEN-1:0]     op_a;
    logic [XLEN-1:0]     op_b;
    logic [XLEN-1:0]     hi;
    logic [XLEN-1:0]     lo;

    logic [2*XLEN-1:0]   prod_s;
    logic [2*XLEN-1:0]   prod_u;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [XLEN-1:0]     den_s;
    logic [XLEN-1:0]     den_u;
    logic [XLEN-1:0]     mag_q;
    logic [XLEN-1:0]     mag_r;
    logic                res_we;
    logic [2*XLEN-1:0]   res;

    // Hazard and read-back paths are combinational off the E-stage fields and HI/LO.
    assign bus.busy     = (state == ST_RUN);
    assign bus.md_stall = bus.d_is_md & (bus.start | bus.busy);
    assign bus.rd_data  = (bus.md_op == MD_MFHI) ? hi : lo;

    // Result datapath from the latched operands; signed divide works on magnitudes
    // so that 0x80000000 / -1 wraps cleanly to 0x80000000 with zero remainder.
    always_comb begin
        prod_s = {{XLEN{op_a[XLEN-1]}}, op_a} * {{XLEN{op_b[XLEN-1]}}, op_b};
        prod_u = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b};
        mag_a  = op_a[XLEN-1] ? XLEN'(~op_a + XLEN'(1)) : op_a;
        mag_b  = op_b[XLEN-1] ? XLEN'(~op_b + XLEN'(1)) : op_b;
        den_s  = (mag_b == '0) ? XLEN'(1) : mag_b;
        den_u  = (op_b == '0) ? XLEN'(1) : op_b;
        mag_q  = mag_a / den_s;
        mag_r  = mag_a % den_s;
        res_we = 1'b0;
        res    = {hi, lo};
        case (op_q)
            MD_MULT: begin
                res_we = 1'b1;
                res    = prod_s;
            end
            MD_MULTU: begin
                res_we = 1'b1;
                res    = prod_u;
            end
            MD_DIV: begin
                res_we = (op_b != '0);
                res[XLEN-1:0]      = (op_a[XLEN-1] ^ op_b[XLEN-1]) ? XLEN'(~mag_q + XLEN'(1)) : mag_q;
                res[2*XLEN-1:XLEN] = op_a[XLEN-1] ? XLEN'(~mag_r + XLEN'(1)) : mag_r;
            end
            MD_DIVU: begin
                res_we = (op_b != '0);
                res    = {XLEN'(op_a % den_u), XLEN'(op_a / den_u)};
            end
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    // IDLE/RUN sequencer: launch, count down, commit HI/LO on the final edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= MD_NONE;
            op_a  <= '0;
            op_b  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == ST_IDLE) begin
            if (bus.start && is_mul_div(bus.md_op)) begin
                op_q  <= bus.md_op;
                op_a  <= bus.a;
                op_b  <= bus.b;
                cnt   <= (bus.md_op inside {MD_MULT, MD_MULTU}) ? CNT_W'(MULT_CYCLES)
                                                                : CNT_W'(DIV_CYCLES);
                state <= ST_RUN;
            end else if (bus.md_op == MD_MTHI) begin
                hi <= bus.a;
            end else if (bus.md_op == MD_MTLO) begin
                lo <= bus.a;
            end
        end else begin
            if (cnt <= CNT_W'(1)) begin
                cnt   <= '0;
                state <= ST_IDLE;
                if (res_we) begin
                    hi <= res[2*XLEN-1:XLEN];
                    lo <= res[XLEN-1:0];
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: latency, stall, arithmetic corners, reset abort.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mul_div_unit_if mif ();

    mul_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of the HI/LO effect of one op (64-bit math avoids overflow).
    task automatic model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT:  {m_hi, m_lo} = sa * sb;
            MD_MULTU: begin
                up = ua * ub;
                {m_hi, m_lo} = up;
            end
            MD_DIV: if (b != 0) begin
                m_lo = 32'(sa / sb);
                m_hi = 32'(sa % sb);
            end
            MD_DIVU: if (b != 0) begin
                m_lo = 32'(ua / ub);
                m_hi = 32'(ua % ub);
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input string tag,
                          input int inj_cyc = 0, input md_op_e inj_op = MD_NONE,
                          input logic [31:0] inj_a = '0, input logic [31:0] inj_b = '0);
        int          cyc;
        logic [63:0] exp;
        cyc = 0;
        @(negedge clk);
        mif.start   = 1'b1;
        mif.md_op   = op;
        mif.a       = a;
        mif.b       = b;
        mif.d_is_md = 1'b1;
        #1 chk({tag, "_stall_start"}, 64'(mif.md_stall), 64'd1);
        model(op, a, b);
        sb_q.push_back({m_hi, m_lo});
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            mif.start = 1'b0;
            mif.md_op = MD_NONE;
            mif.a     = '0;
            mif.b     = '0;
            #1;
            if (!mif.busy) break;
            cyc++;
            chk({tag, "_stall_busy"}, 64'(mif.md_stall), 64'd1);
            if (cyc == inj_cyc) begin
                mif.start = is_mul_div(inj_op);
                mif.md_op = inj_op;
                mif.a     = inj_a;
                mif.b     = inj_b;
            end
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
        mif.d_is_md = 1'b0;
        #1 chk({tag, "_stall_idle"}, 64'(mif.md_stall), 64'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        mif.md_op = MD_MFHI;
        #1 chk({tag, "_hi"}, 64'(mif.rd_data), 64'(exp[63:32]));
        mif.md_op = MD_MFLO;
        #1 chk({tag, "_lo"}, 64'(mif.rd_data), 64'(exp[31:0]));
        mif.md_op = MD_NONE;
    endtask

    task automatic mt(input md_op_e op, input logic [31:0] val, input string tag);
        @(negedge clk);
        mif.start   = 1'b0;
        mif.md_op   = op;
        mif.a       = val;
        mif.d_is_md = 1'b0;
        model(op, val, '0);
        @(negedge clk);
        mif.md_op = (op == MD_MTHI) ? MD_MFHI : MD_MFLO;
        mif.a     = '0;
        #1;
        chk({tag, "_busy"}, 64'(mif.busy), 64'd0);
        chk({tag, "_rd"}, 64'(mif.rd_data), 64'((op == MD_MTHI) ? m_hi : m_lo));
        mif.md_op = MD_NONE;
    endtask

    initial begin
        mif.start   = 1'b0;
        mif.md_op   = MD_NONE;
        mif.a       = '0;
        mif.b       = '0;
        mif.d_is_md = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Post-reset state.
        #1;
        chk("rst_busy", 64'(mif.busy), 64'd0);
        mif.md_op = MD_MFHI;
        #1 chk("rst_hi", 64'(mif.rd_data), 64'd0);
        mif.md_op = MD_MFLO;
        #1 chk("rst_lo", 64'(mif.rd_data), 64'd0);
        mif.md_op   = MD_NONE;
        mif.d_is_md = 1'b1;
        #1 chk("rst_stall_nostart", 64'(mif.md_stall), 64'd0);
        mif.start = 1'b1;
        mif.md_op = MD_MULT;
        #1 chk("rst_stall_start", 64'(mif.md_stall), 64'd1);
        mif.start   = 1'b0;
        mif.md_op   = MD_NONE;
        mif.d_is_md = 1'b0;

        run_op(MD_MULT,  32'hFFFF_FFFF, 32'd2, 5, "mult_neg");
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, "multu");
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, "div_m7_2");
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
        run_op(MD_DIV,   32'd7, 32'hFFFF_FFFE, 10, "div_7_m2");
        mt(MD_MTHI, 32'h11, "mthi11");
        mt(MD_MTLO, 32'h11, "mtlo11");
        run_op(MD_DIVU,  32'd7, 32'd0, 10, "divu_by0");
        run_op(MD_MULT,  32'h1234_5678, 32'h9ABC_DEF0, 5, "mult_restart",
               2, MD_MULT, 32'd3, 32'd3);
        run_op(MD_DIVU,  32'd1000, 32'd7, 10, "divu_mt_busy",
               4, MD_MTHI, 32'hDEAD, 32'd0);
        mt(MD_MTLO, 32'h1234, "mtlo1234");

        // Abort a divide with reset during its third busy cycle.
        @(negedge clk);
        mif.start = 1'b1;
        mif.md_op = MD_DIV;
        mif.a     = 32'd100;
        mif.b     = 32'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mif.start = 1'b0;
            mif.md_op = MD_NONE;
        end
        #1 chk("abort_busy_before", 64'(mif.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1 chk("abort_busy", 64'(mif.busy), 64'd0);
        mif.md_op = MD_MFHI;
        #1 chk("abort_hi", 64'(mif.rd_data), 64'd0);
        mif.md_op = MD_MFLO;
        #1 chk("abort_lo", 64'(mif.rd_data), 64'd0);
        mif.md_op = MD_NONE;
        repeat (15) @(negedge clk);
        #1 chk("abort_busy_late", 64'(mif.busy), 64'd0);
        mif.md_op = MD_MFHI;
        #1 chk("abort_hi_late", 64'(mif.rd_data), 64'(m_hi));
        mif.md_op = MD_MFLO;
        #1 chk("abort_lo_late", 64'(mif.rd_data), 64'(m_lo));
        mif.md_op = MD_NONE;

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
